// File: rtl/term_stream_if.sv
// Group-input handshake and per-lane term stream outputs of the term stream encoder.
// The master side feeds groups in and watches the streams; the slave side is the encoder.
interface term_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*DATA_WIDTH-1:0] in_mag;
  logic [3:0]              in_sign;
  logic                    naf_en;
  logic                    out_valid;
  logic                    group_start;
  logic                    group_last;
  logic [3:0]              term_stream;
  logic [3:0]              term_sign_stream;

  modport master (
    output in_valid, in_mag, in_sign, naf_en,
    input  in_ready, out_valid, group_start, group_last, term_stream, term_sign_stream
  );

  modport slave (
    input  in_valid, in_mag, in_sign, naf_en,
    output in_ready, out_valid, group_start, group_last, term_stream, term_sign_stream
  );
endinterface

// File: rtl/term_stream_encoder.sv
// Recodes a 4-lane sign-magnitude group (binary or NAF) at capture and streams the
// signed power-of-two digits MSB-first, one position per cycle, in fixed-length frames.
module term_stream_encoder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power_on,
  term_stream_if.slave bus
);
  localparam int L  = DATA_WIDTH + 1;
  localparam int CW = $clog2(L);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                buf_full_q, buf_full_d;
  logic [3:0][L-1:0]   buf_pos_q, buf_pos_d;
  logic [3:0][L-1:0]   buf_neg_q, buf_neg_d;
  logic [3:0]          buf_sign_q, buf_sign_d;
  logic [3:0][L-1:0]   sh_pos_q, sh_pos_d;
  logic [3:0][L-1:0]   sh_neg_q, sh_neg_d;
  logic [3:0]          sh_sign_q, sh_sign_d;

  logic [3:0][L-1:0]   rec_pos;
  logic [3:0][L-1:0]   rec_neg;
  logic                accept;
  logic                load;
  logic                in_shift;

  assign bus.in_ready = power_on & ~buf_full_q & ~reset;
  assign accept       = bus.in_valid & bus.in_ready;
  assign in_shift     = (state_q == SHIFT);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : lane_g
      logic [DATA_WIDTH-1:0] mag;
      logic [DATA_WIDTH+1:0] x_ext;
      logic [DATA_WIDTH+1:0] x3;
      logic [L-1:0]          naf_pos;
      logic [L-1:0]          naf_neg;
      logic                  digit_pos;
      logic                  digit_neg;

      // Canonical NAF: compare x with 3x; a differing bit above k gives digit k.
      assign mag     = bus.in_mag[gi*DATA_WIDTH +: DATA_WIDTH];
      assign x_ext   = {2'b00, mag};
      assign x3      = x_ext + {x_ext[DATA_WIDTH:0], 1'b0};
      assign naf_pos = x3[L:1] & ~x_ext[L:1];
      assign naf_neg = ~x3[L:1] & x_ext[L:1];

      assign rec_pos[gi] = bus.naf_en ? naf_pos : {1'b0, mag};
      assign rec_neg[gi] = bus.naf_en ? naf_neg : '0;

      assign digit_pos = sh_pos_q[gi][cnt_q];
      assign digit_neg = sh_neg_q[gi][cnt_q];
      assign bus.term_stream[gi]      = in_shift & (digit_pos | digit_neg);
      assign bus.term_sign_stream[gi] = in_shift & (digit_pos | digit_neg)
                                        & (sh_sign_q[gi] ^ digit_neg);
    end
  endgenerate

  assign bus.out_valid   = in_shift;
  assign bus.group_start = in_shift & (cnt_q == CW'(DATA_WIDTH));
  assign bus.group_last  = in_shift & (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    buf_pos_d  = buf_pos_q;
    buf_neg_d  = buf_neg_q;
    buf_sign_d = buf_sign_q;
    sh_pos_d   = sh_pos_q;
    sh_neg_d   = sh_neg_q;
    sh_sign_d  = sh_sign_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (buf_full_q) load = 1'b1;
          else            state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sh_pos_d   = buf_pos_q;
      sh_neg_d   = buf_neg_q;
      sh_sign_d  = buf_sign_q;
      cnt_d      = CW'(DATA_WIDTH);
      buf_full_d = 1'b0;
    end

    // accept only fires with the buffer empty, so it never collides with a drain
    if (accept) begin
      buf_full_d = 1'b1;
      buf_pos_d  = rec_pos;
      buf_neg_d  = rec_neg;
      buf_sign_d = bus.in_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
      buf_pos_q  <= '0;
      buf_neg_q  <= '0;
      buf_sign_q <= '0;
      sh_pos_q   <= '0;
      sh_neg_q   <= '0;
      sh_sign_q  <= '0;
    end else if (power_on) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      buf_pos_q  <= buf_pos_d;
      buf_neg_q  <= buf_neg_d;
      buf_sign_q <= buf_sign_d;
      sh_pos_q   <= sh_pos_d;
      sh_neg_q   <= sh_neg_d;
      sh_sign_q  <= sh_sign_d;
    end
  end
endmodule

// File: tb/tb_term_stream_encoder.sv
// Directed bench for term_stream_encoder: a table of groups with hand-computed digit
// masks, plus back-to-back, power-freeze and mid-frame reset sequences.
module tb_term_stream_encoder;
  localparam int DW = 8;

  typedef struct {
    logic [3:0][DW-1:0] mag;
    logic [3:0]         sign;
    logic               naf;
    logic [3:0][DW:0]   pos;
    logic [3:0][DW:0]   neg;
  } vec_t;

  logic clk;
  logic reset;
  logic power_on;
  int   n_vec;
  int   n_miss;
  vec_t vecs[6];

  term_stream_if #(.DATA_WIDTH(DW)) bus ();

  term_stream_encoder #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .power_on (power_on),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got hang, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] exp_word(input int v, input int p);
    logic [3:0] t;
    logic [3:0] s;
    for (int i = 0; i < 4; i++) begin
      t[i] = vecs[v].pos[i][p] | vecs[v].neg[i][p];
      s[i] = t[i] & (vecs[v].sign[i] ^ vecs[v].neg[i][p]);
    end
    return {1'b1, (p == DW), (p == 0), t, s};
  endfunction

  function automatic logic [10:0] act_word();
    return {bus.out_valid, bus.group_start, bus.group_last, bus.term_stream, bus.term_sign_stream};
  endfunction

  task automatic drive_group(input int v);
    bus.in_mag  = vecs[v].mag;
    bus.in_sign = vecs[v].sign;
    bus.naf_en  = vecs[v].naf;
  endtask

  task automatic send(input int v);
    drive_group(v);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.group_start && waited < 30) begin
      waited++;
      @(negedge clk);
    end
    check("group_start_seen", 32'(bus.group_start), 32'd1);
  endtask

  // Entered at the negedge of the expected group_start cycle; leaves at group_last.
  task automatic check_frame(input int v);
    for (int p = DW; p >= 0; p--) begin
      if (p != DW) @(negedge clk);
      check($sformatf("frame_v%0d_p%0d", v, p), 32'(act_word()), 32'(exp_word(v, p)));
    end
    $display("frame v%0d done: mag=%h sign=%b naf=%0d", v, vecs[v].mag, vecs[v].sign, vecs[v].naf);
  endtask

  initial begin
    int w;
    int plist[12];
    int seq[3];
    int ov_cnt;

    n_vec = 0;
    n_miss = 0;

    // lane0 7 NAF: +8 -1
    vecs[0].mag = {8'd0, 8'd0, 8'd0, 8'd7};     vecs[0].sign = 4'b0000; vecs[0].naf = 1'b1;
    vecs[0].pos = {9'h000, 9'h000, 9'h000, 9'h008}; vecs[0].neg = {9'h000, 9'h000, 9'h000, 9'h001};
    // lane0 7 binary: bits 2..0
    vecs[1].mag = {8'd0, 8'd0, 8'd0, 8'd7};     vecs[1].sign = 4'b0000; vecs[1].naf = 1'b0;
    vecs[1].pos = {9'h000, 9'h000, 9'h000, 9'h007}; vecs[1].neg = '0;
    // lane1 -255 NAF: -(256 - 1); lane2 negative zero
    vecs[2].mag = {8'd0, 8'd0, 8'd255, 8'd0};   vecs[2].sign = 4'b0110; vecs[2].naf = 1'b1;
    vecs[2].pos = {9'h000, 9'h000, 9'h100, 9'h000}; vecs[2].neg = {9'h000, 9'h000, 9'h001, 9'h000};
    // 85, 170 already NAF; 3 = 4-1; 6 = 8-2
    vecs[3].mag = {8'd6, 8'd3, 8'd170, 8'd85};  vecs[3].sign = 4'b1010; vecs[3].naf = 1'b1;
    vecs[3].pos = {9'h008, 9'h004, 9'h0AA, 9'h055}; vecs[3].neg = {9'h002, 9'h001, 9'h000, 9'h000};
    // binary mode with mixed signs
    vecs[4].mag = {8'd0, 8'd1, 8'd128, 8'd255}; vecs[4].sign = 4'b0101; vecs[4].naf = 1'b0;
    vecs[4].pos = {9'h000, 9'h001, 9'h080, 9'h0FF}; vecs[4].neg = '0;
    // lane3 -11 NAF: -(16 - 4 - 1); zero lanes with sign set
    vecs[5].mag = {8'd11, 8'd0, 8'd0, 8'd0};    vecs[5].sign = 4'b1111; vecs[5].naf = 1'b1;
    vecs[5].pos = {9'h010, 9'h000, 9'h000, 9'h000}; vecs[5].neg = {9'h005, 9'h000, 9'h000, 9'h000};

    reset = 1'b1;
    power_on = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mag = '0;
    bus.in_sign = '0;
    bus.naf_en = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_ready", 32'(bus.in_ready), 32'd0);
    check("reset_outputs", 32'(act_word()), 32'd0);
    reset = 1'b0;
    #1 check("post_reset_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      send(v);
      wait_start(w);
      check_frame(v);
    end

    // back-to-back: in_valid held high across three groups
    repeat (3) @(posedge clk);
    #1;
    seq[0] = 0; seq[1] = 3; seq[2] = 5;
    fork
      begin
        bus.in_valid = 1'b1;
        for (int g = 0; g < 3; g++) begin
          drive_group(seq[g]);
          for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
          end
          check("b2b_ready", 32'(bus.in_ready), 32'd1);
          @(posedge clk);
          #1;
          if (g == 1) begin
            @(negedge clk);
            check("b2b_ready_low_when_full", 32'(bus.in_ready), 32'd0);
          end
        end
        bus.in_valid = 1'b0;
      end
      begin
        wait_start(w);
        check("b2b_latency", 32'(w), 32'd2);
        check_frame(seq[0]);
        @(negedge clk);
        check_frame(seq[1]);
        @(negedge clk);
        check_frame(seq[2]);
        @(negedge clk);
        check("b2b_idle_after", 32'(bus.out_valid), 32'd0);
      end
    join

    // power_on low for three edges while position 5 is showing
    repeat (2) @(posedge clk);
    #1;
    plist = '{8, 7, 6, 5, 5, 5, 5, 4, 3, 2, 1, 0};
    send(0);
    wait_start(w);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("power_k%0d", k), 32'(act_word()), 32'(exp_word(0, plist[k])));
      if (k == 3) power_on = 1'b0;
      if (k == 4) check("power_off_ready", 32'(bus.in_ready), 32'd0);
      if (k == 6) power_on = 1'b1;
    end
    $display("power freeze frame done");

    // reset at position 4 with a queued group behind the active frame
    repeat (2) @(posedge clk);
    #1;
    send(3);
    wait_start(w);
    drive_group(4);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("queued_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("pre_reset_p4", 32'(act_word()), 32'(exp_word(3, 4)));
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", 32'(act_word()), 32'd0);
    check("reset_mid_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    #1 check("reset_release_ready", 32'(bus.in_ready), 32'd1);
    ov_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check("queued_discarded", 32'(ov_cnt), 32'd0);
    $display("mid-frame reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
